// File: rtl/periph_bus_master.sv
// Single-outstanding initiator for the peripheral register bus.
// Partial-byte stores become a read, a byte merge and one full-word write.
module periph_bus_master #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  bus_wr_en_o,
    output logic [ADDR_WIDTH-1:0] bus_wr_addr_o,
    output logic [31:0]           bus_wr_data_o,
    output logic [ADDR_WIDTH-1:0] bus_rd_addr_o,
    input  logic [31:0]           bus_rd_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        RMW_RD,
        RMW_CAP,
        WR,
        ERR,
        RESP
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [3:0]              r_be;

    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_bus_wr_en;
    logic [ADDR_WIDTH-1:0]   r_bus_wr_addr;
    logic [31:0]             r_bus_wr_data;
    logic [ADDR_WIDTH-1:0]   r_bus_rd_addr;

    logic                    w_misaligned;
    logic [ADDR_WIDTH-1:0]   w_req_addr_word;
    logic [31:0]             w_merged;

    assign w_misaligned    = (req_addr_i[1:0] != 2'b00);
    assign w_req_addr_word = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};

    // Enabled bytes come from the store, the rest from the word just read back.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign w_merged[8*gi +: 8] = r_be[gi] ? r_wdata[8*gi +: 8]
                                                  : bus_rd_data_i[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_bus_wr_en   <= 1'b0;
            r_bus_wr_addr <= '0;
            r_bus_wr_data <= '0;
            r_bus_rd_addr <= '0;
        end else begin
            r_bus_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_addr      <= w_req_addr_word;
                        r_wdata     <= req_wdata_i;
                        r_be        <= req_be_i;
                        r_rsp_rdata <= '0;
                        if (w_misaligned) begin
                            r_rsp_err <= 1'b1;
                            r_state   <= ERR;
                        end else if (!req_we_i) begin
                            r_bus_rd_addr <= w_req_addr_word;
                            r_state       <= RD;
                        end else if (req_be_i == 4'hF) begin
                            r_bus_wr_en   <= 1'b1;
                            r_bus_wr_addr <= w_req_addr_word;
                            r_bus_wr_data <= req_wdata_i;
                            r_state       <= WR;
                        end else if (req_be_i == 4'h0) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_bus_rd_addr <= w_req_addr_word;
                            r_state       <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    r_state <= CAP;
                end
                CAP: begin
                    r_rsp_rdata <= bus_rd_data_i;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RMW_RD: begin
                    r_state <= RMW_CAP;
                end
                RMW_CAP: begin
                    r_bus_wr_en   <= 1'b1;
                    r_bus_wr_addr <= r_addr;
                    r_bus_wr_data <= w_merged;
                    r_state       <= WR;
                end
                WR: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                ERR: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign bus_wr_en_o   = r_bus_wr_en;
    assign bus_wr_addr_o = r_bus_wr_addr;
    assign bus_wr_data_o = r_bus_wr_data;
    assign bus_rd_addr_o = r_bus_rd_addr;

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Initiator for the simple peripheral register bus used by the GPIO block and the other memory-mapped peripherals.
- Accepts one load/store at a time from the core LSU over a valid/ready request channel.
- Drives the peripheral bus signals wr_en/wr_addr/wr_data/rd_addr, captures read data one cycle after the read address is presented, and returns a valid/ready response.
- Performs read-modify-write for partial byte-enable stores, because peripherals only accept full-word writes.

Parameters:
ADDR_WIDTH, 32, width of request and bus addresses. Data is fixed at 32 bits; byte enables are fixed at 4 bits.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when high with req_valid_i
req_we_i  input  1  1 = store, 0 = load
req_addr_i  input  ADDR_WIDTH  byte address
req_wdata_i  input  32  store data
req_be_i  input  4  store byte enables (ignored for loads)
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed
rsp_rdata_o  output  32  load data; 0 for stores and errors
rsp_err_o  output  1  misaligned access
bus_wr_en_o  output  1  peripheral write enable
bus_wr_addr_o  output  ADDR_WIDTH  peripheral write address
bus_wr_data_o  output  32  peripheral write data
bus_rd_addr_o  output  ADDR_WIDTH  peripheral read address
bus_rd_data_i  input  32  peripheral read data

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Reset values: all outputs 0, except req_ready_o = 1 (state IDLE). Reset asserted mid-operation forces IDLE at once: bus_wr_en_o drops without waiting for a clock edge, and the in-flight request is discarded with no response.
- Responder contract: the peripheral registers rd_addr at a clock edge and drives rd_data combinationally from that registered address. Read data is therefore valid in the cycle after bus_rd_addr_o is held across an edge. Writes commit at the edge where bus_wr_en_o = 1.
- Request channel: req_ready_o = (state == IDLE), taken from the registered state. On a valid&ready edge the block latches we, addr, wdata and be.
- Bus address: always {addr[ADDR_WIDTH-1:2], 2'b00}.
- Request decode on accept:
  - addr[1:0] != 0 -> ERR.
  - load -> RD.
  - store, be == 4'hF -> WR.
  - store, be == 0 -> RESP, no bus activity.
  - store, other be -> RMW_RD.
- States:
  - IDLE: wait for a request.
  - RD: bus_rd_addr_o = latched address. Next state CAP.
  - CAP: register bus_rd_data_i into the response data. Next state RESP.
  - RMW_RD: same as RD. Next state RMW_CAP.
  - RMW_CAP: merge. For each byte i, byte = be[i] ? wdata byte i : bus_rd_data_i byte i. Store the result in the write-data register. Next state WR.
  - WR: bus_wr_en_o = 1 for exactly this one cycle, with bus_wr_addr_o and bus_wr_data_o valid. Next state RESP.
  - ERR: rsp_err_o = 1. Next state RESP.
  - RESP: rsp_valid_o = 1, with rsp_rdata_o and rsp_err_o held stable. Stays in RESP until rsp_ready_i = 1, then goes to IDLE.
- Response values: rsp_rdata_o = 0 for stores and errors. rsp_err_o is cleared on leaving RESP.
- Bus outputs outside their active states:
  - bus_wr_en_o = 0 outside WR.
  - bus_wr_addr_o and bus_wr_data_o hold their last values.
  - bus_rd_addr_o holds the last latched address.
- Latency, counted from the accept edge N, with rsp_ready_i held high:
  - load: rsp_valid_o in cycle N+3.
  - full store: bus_wr_en_o in N+1, response in N+2.
  - partial store: write in N+3, response in N+4.
  - be = 0 store or error: response in N+1 (error passes through ERR, so N+2).
- Ordering: no new request is accepted before the previous response handshake completes. The next accept is possible in the cycle after the RESP handshake.
- Request inputs are sampled only at accept; changes while busy are ignored.

Test Plan:
- Full store: addr 0x4, data 0x0000_0005, be 0xF -> bus_wr_en_o high for exactly one cycle at N+1 with bus_wr_addr_o = 0x4 and bus_wr_data_o = 0x5; response at N+2 with rdata = 0 and err = 0.
- Load: addr 0x4 with the GPIO data register holding 0x5 -> bus_rd_addr_o = 0x4 at N+1; rsp_rdata_o = 0x0000_0005 at N+3.
- Partial store: register holds 0x1234_5678; store be = 4'b0001, data 0xAA to 0x4 -> one bus write of 0x1234_56AA; response at N+4.
- Misaligned: load from 0x6 -> no bus_wr_en_o and no change on bus_rd_addr_o; response with err = 1 and rdata = 0.
- Backpressure: rsp_ready_i held low 3 cycles -> rsp_valid_o and rsp_rdata_o stable throughout and req_ready_o = 0; IDLE the cycle after rsp_ready_i rises, and a back-to-back second request is accepted then.
- Reset during RMW_CAP -> bus_wr_en_o never pulses, all outputs return to reset values immediately, and the next request behaves normally.
